m68k30_async_mem_slave: RTL and testbench

- Synthesizable 32-bit port bus slave on the WF68K30L asynchronous bus. It sits directly downstream of the CPU core.
- Decodes ADR_OUT, SIZE and RWn, drives a single-port synchronous RAM with byte enables, and returns DATA_IN with DSACKn (32-bit port acknowledge) or BERRn.
- Replaces the behavioural bench memory so that programs run on silicon and in simulation with the same bus timing.

---
 rtl/m68k30_async_mem_slave.sv | 222 ++++++++++++++++++++++
 tb/tb_m68k30_async_mem_slave.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m68k30_async_mem_slave.sv
// WF68K30L asynchronous-bus RAM slave: 32-bit port, DSACKn=00 acknowledge, optional wait states.
// Define M68K30_SLAVE_RANGE_CHECK_EN to answer out-of-window or boundary-crossing cycles with BERRn.
module m68k30_async_mem_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned MEM_AW      = 6,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              CLK,
  input  logic              RESET_INn,
  input  logic [31:0]       ADR_IN,
  input  logic [31:0]       DATA_WR,
  output logic [31:0]       DATA_RD,
  input  logic              ASn,
  input  logic              DSn,
  input  logic              RWn,
  input  logic [1:0]        SIZE,
  output logic [1:0]        DSACKn,
  output logic              BERRn,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_WAIT,
    S_ACCESS,
    S_RDATA,
    S_ACK,
    S_BERR
  } state_t;

  state_t            state_q;
  logic [3:0]        wait_cnt_q;
  logic              armed_q;
  logic [31:0]       adr_q;
  logic [1:0]        size_q;
  logic              rwn_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_rd_q;
  logic [1:0]        dsack_n_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic [3:0]        mem_be_q;
  logic              mem_we_q;
  logic              mem_re_q;

  logic [2:0]        byte_cnt_d;
  logic [2:0]        lane_end_d;
  logic [3:0]        lane_be_d;
  logic [MEM_AW-1:0] word_addr_d;
  logic              range_err_d;
  logic              enter_access_d;

  // SIZE=00 encodes a long word; the other codes are the byte count itself.
  assign byte_cnt_d  = (size_q == 2'b00) ? 3'd4 : {1'b0, size_q};
  assign lane_end_d  = {1'b0, adr_q[1:0]} + byte_cnt_d;
  assign word_addr_d = MEM_AW'((adr_q - BASE_ADDR) >> 2);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    lane_be_d = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if ((3'(k) >= {1'b0, adr_q[1:0]}) && (3'(k) < lane_end_d)) begin
        lane_be_d[2'(3 - k)] = 1'b1;
      end
    end
  end

`ifdef M68K30_SLAVE_RANGE_CHECK_EN
  localparam logic [32:0] MEM_BYTES = 33'd4 << MEM_AW;

  logic [31:0] byte_off_d;
  logic        berr_n_q;

  assign byte_off_d  = adr_q - BASE_ADDR;
  assign range_err_d = (adr_q < BASE_ADDR) ||
                       ({1'b0, byte_off_d} >= MEM_BYTES) ||
                       (lane_end_d > 3'd4);
  assign BERRn       = berr_n_q;
`else
  assign range_err_d = 1'b0;
  assign BERRn       = 1'b1;
`endif

  // The RAM strobe is raised on the edge that enters ACCESS, so it is high exactly during ACCESS.
  assign enter_access_d = !ASn &&
                          (((state_q == S_DECODE) && !range_err_d && (WAIT_STATES == 0)) ||
                           ((state_q == S_WAIT) && (wait_cnt_q == 4'd1)));

  // NOTE: sequential state uses non-blocking assignments only; reset is asynchronous and active low.
  always_ff @(posedge CLK or negedge RESET_INn) begin
    if (!RESET_INn) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= 4'd0;
      armed_q     <= 1'b0;
      adr_q       <= 32'd0;
      size_q      <= 2'b00;
      rwn_q       <= 1'b1;
      wdata_q     <= 32'd0;
      data_rd_q   <= 32'd0;
      dsack_n_q   <= 2'b11;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'b0000;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
`ifdef M68K30_SLAVE_RANGE_CHECK_EN
      berr_n_q    <= 1'b1;
`endif
    end else begin
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      if (enter_access_d) begin
        mem_we_q <= !rwn_q;
        mem_re_q <= rwn_q;
        if (!rwn_q) mem_wdata_q <= wdata_q;
      end

      case (state_q)
        S_IDLE: begin
          // A new cycle needs ASn seen high in IDLE first, so one CPU cycle is serviced once.
          if (ASn) begin
            armed_q <= 1'b1;
          end else if (!DSn && armed_q) begin
            armed_q <= 1'b0;
            adr_q   <= ADR_IN;
            size_q  <= SIZE;
            rwn_q   <= RWn;
            wdata_q <= DATA_WR;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (ASn) begin
            state_q <= S_IDLE;
          end else if (range_err_d) begin
            state_q <= S_BERR;
`ifdef M68K30_SLAVE_RANGE_CHECK_EN
            berr_n_q <= 1'b0;
`endif
          end else begin
            mem_addr_q <= word_addr_d;
            mem_be_q   <= rwn_q ? 4'b1111 : lane_be_d;
            wait_cnt_q <= 4'(WAIT_STATES);
            state_q    <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end

        S_WAIT: begin
          if (ASn) begin
            mem_be_q <= 4'b0000;
            state_q  <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q - 4'd1;
            if (wait_cnt_q == 4'd1) state_q <= S_ACCESS;
          end
        end

        S_ACCESS: begin
          // The strobe has already gone out; a late ASn negation only suppresses the acknowledge.
          if (ASn) begin
            mem_be_q <= 4'b0000;
            state_q  <= S_IDLE;
          end else if (rwn_q) begin
            state_q <= S_RDATA;
          end else begin
            dsack_n_q <= 2'b00;
            state_q   <= S_ACK;
          end
        end

        S_RDATA: begin
          if (ASn) begin
            mem_be_q <= 4'b0000;
            state_q  <= S_IDLE;
          end else begin
            data_rd_q <= mem_rdata;
            dsack_n_q <= 2'b00;
            state_q   <= S_ACK;
          end
        end

        S_ACK: begin
          if (ASn) begin
            data_rd_q <= 32'd0;
            dsack_n_q <= 2'b11;
            mem_be_q  <= 4'b0000;
            state_q   <= S_IDLE;
          end
        end

        S_BERR: begin
          if (ASn) begin
`ifdef M68K30_SLAVE_RANGE_CHECK_EN
            berr_n_q <= 1'b1;
`endif
            state_q  <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign DATA_RD   = data_rd_q;
  assign DSACKn    = dsack_n_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;

  strobe_exclusive_a: assert property (@(posedge CLK) disable iff (!RESET_INn) !(mem_we_q && mem_re_q));

endmodule

// File: tb/tb_m68k30_async_mem_slave.sv
// Directed bench for m68k30_async_mem_slave: one instance with WAIT_STATES=1, one with WAIT_STATES=3.
// Each instance has its own behavioural byte-enable RAM with one-cycle read latency.
module tb_m68k30_async_mem_slave;

  logic        CLK = 1'b0;
  logic        RESET_INn = 1'b1;
  logic [31:0] ADR_IN = 32'd0;
  logic [31:0] DATA_WR = 32'd0;
  logic        ASn = 1'b1;
  logic        DSn = 1'b1;
  logic        RWn = 1'b1;
  logic [1:0]  SIZE = 2'b00;

  logic [31:0] a_data_rd, b_data_rd;
  logic [1:0]  a_dsack_n, b_dsack_n;
  logic        a_berr_n, b_berr_n;
  logic [5:0]  a_mem_addr, b_mem_addr;
  logic [31:0] a_mem_wdata, b_mem_wdata;
  logic [3:0]  a_mem_be, b_mem_be;
  logic        a_mem_we, b_mem_we, a_mem_re, b_mem_re;
  logic [31:0] a_mem_rdata = 32'd0;
  logic [31:0] b_mem_rdata = 32'd0;

  int checks = 0;
  int errors = 0;
  bit sel_b = 1'b0;
  logic [31:0] exp_word10;

  always #5 CLK = ~CLK;

  m68k30_async_mem_slave #(.BASE_ADDR(32'h0), .MEM_AW(6), .WAIT_STATES(1)) dut_a (
    .CLK(CLK), .RESET_INn(RESET_INn), .ADR_IN(ADR_IN), .DATA_WR(DATA_WR), .DATA_RD(a_data_rd),
    .ASn(ASn), .DSn(DSn), .RWn(RWn), .SIZE(SIZE), .DSACKn(a_dsack_n), .BERRn(a_berr_n),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .mem_we(a_mem_we),
    .mem_re(a_mem_re), .mem_rdata(a_mem_rdata));

  m68k30_async_mem_slave #(.BASE_ADDR(32'h0), .MEM_AW(6), .WAIT_STATES(3)) dut_b (
    .CLK(CLK), .RESET_INn(RESET_INn), .ADR_IN(ADR_IN), .DATA_WR(DATA_WR), .DATA_RD(b_data_rd),
    .ASn(ASn), .DSn(DSn), .RWn(RWn), .SIZE(SIZE), .DSACKn(b_dsack_n), .BERRn(b_berr_n),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .mem_we(b_mem_we),
    .mem_re(b_mem_re), .mem_rdata(b_mem_rdata));

  logic [31:0] ram_a [64];
  logic [31:0] ram_b [64];
  int          we_cnt_a = 0, re_cnt_a = 0, we_cnt_b = 0, re_cnt_b = 0;
  logic [5:0]  last_addr_a = '0;
  logic [3:0]  last_be_a = '0, last_rbe_a = '0;
  logic [31:0] last_wdata_a = '0;

  always @(posedge CLK) begin
    if (a_mem_we) begin
      for (int k = 0; k < 4; k++) if (a_mem_be[k]) ram_a[a_mem_addr][k*8 +: 8] <= a_mem_wdata[k*8 +: 8];
      we_cnt_a     <= we_cnt_a + 1;
      last_addr_a  <= a_mem_addr;
      last_be_a    <= a_mem_be;
      last_wdata_a <= a_mem_wdata;
    end
    if (a_mem_re) begin
      a_mem_rdata <= ram_a[a_mem_addr];
      re_cnt_a    <= re_cnt_a + 1;
      last_rbe_a  <= a_mem_be;
    end
  end

  always @(posedge CLK) begin
    if (b_mem_we) begin
      for (int k = 0; k < 4; k++) if (b_mem_be[k]) ram_b[b_mem_addr][k*8 +: 8] <= b_mem_wdata[k*8 +: 8];
      we_cnt_b <= we_cnt_b + 1;
    end
    if (b_mem_re) begin
      b_mem_rdata <= ram_b[b_mem_addr];
      re_cnt_b    <= re_cnt_b + 1;
    end
  end

  logic [1:0]  dsack_n;
  logic        berr_n;
  logic [31:0] data_rd;
  assign dsack_n = sel_b ? b_dsack_n : a_dsack_n;
  assign berr_n  = sel_b ? b_berr_n  : a_berr_n;
  assign data_rd = sel_b ? b_data_rd : a_data_rd;

  // One CPU bus cycle, entered and left #1 after a rising edge. lat counts edges after the
  // strobe-sampling edge; kind is 0 on timeout, 1 on DSACKn, 2 on BERRn.
  task automatic bus_cycle(input logic rd, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [31:0] wd, output int lat, output int kind,
                           output logic [31:0] rdata, output logic [1:0] post_dsack,
                           output logic post_berr, output logic [31:0] post_data);
    ADR_IN = addr; SIZE = sz; RWn = rd; DATA_WR = wd; ASn = 1'b0; DSn = 1'b0;
    @(posedge CLK);
    lat = 0; kind = 0; rdata = 32'd0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge CLK); #1;
      if (dsack_n == 2'b00) begin lat = i; kind = 1; rdata = data_rd; break; end
      if (berr_n == 1'b0) begin lat = i; kind = 2; break; end
    end
    ASn = 1'b1; DSn = 1'b1;
    @(posedge CLK); #1;
    post_dsack = dsack_n; post_berr = berr_n; post_data = data_rd;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    #1 RESET_INn = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if ({a_dsack_n, a_berr_n} !== 3'b111) begin errors++; $display("FAIL reset_dsack_berr got %b exp 111", {a_dsack_n, a_berr_n}); end
    checks++; if (a_data_rd !== 32'd0) begin errors++; $display("FAIL reset_data_rd got %h exp 0", a_data_rd); end
    checks++; if ({a_mem_we, a_mem_re, a_mem_be} !== 6'd0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", {a_mem_we, a_mem_re, a_mem_be}); end
    checks++; if ({a_mem_addr, a_mem_wdata} !== 38'd0) begin errors++; $display("FAIL reset_addr_wdata got %h/%h exp 0/0", a_mem_addr, a_mem_wdata); end
    @(negedge CLK) RESET_INn = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
  endtask

  task automatic test_write_read;
    int lat, kind, we0, re0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    we0 = we_cnt_a; re0 = re_cnt_a;
    bus_cycle(1'b0, 32'h10, 2'b00, 32'hDEADBEEF, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || lat !== 3) begin errors++; $display("FAIL wr_latency got kind %0d lat %0d exp kind 1 lat 3", kind, lat); end
    checks++; if (we_cnt_a - we0 !== 1 || re_cnt_a !== re0) begin errors++; $display("FAIL wr_strobes got we %0d re %0d exp we 1 re 0", we_cnt_a - we0, re_cnt_a - re0); end
    checks++; if ({last_addr_a, last_be_a} !== {6'd4, 4'b1111}) begin errors++; $display("FAIL wr_addr_be got %0d/%b exp 4/1111", last_addr_a, last_be_a); end
    checks++; if (last_wdata_a !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata got %h exp deadbeef", last_wdata_a); end
    checks++; if (pds !== 2'b11) begin errors++; $display("FAIL wr_release got %b exp 11", pds); end
    we0 = we_cnt_a; re0 = re_cnt_a;
    bus_cycle(1'b1, 32'h10, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || lat !== 4) begin errors++; $display("FAIL rd_latency got kind %0d lat %0d exp kind 1 lat 4", kind, lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", rd); end
    checks++; if (re_cnt_a - re0 !== 1 || we_cnt_a !== we0 || last_rbe_a !== 4'b1111) begin errors++; $display("FAIL rd_strobes got re %0d we %0d be %b exp 1 0 1111", re_cnt_a - re0, we_cnt_a - we0, last_rbe_a); end
    checks++; if (pds !== 2'b11 || pdata !== 32'd0) begin errors++; $display("FAIL rd_release got %b/%h exp 11/0", pds, pdata); end
    exp_word10 = 32'hDEADBEEF;
  endtask

  task automatic test_byte_write;
    int lat, kind; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    bus_cycle(1'b0, 32'h12, 2'b01, 32'h0000AB00, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || lat !== 3) begin errors++; $display("FAIL byte_latency got kind %0d lat %0d exp 1 3", kind, lat); end
    checks++; if ({last_addr_a, last_be_a} !== {6'd4, 4'b0010}) begin errors++; $display("FAIL byte_addr_be got %0d/%b exp 4/0010", last_addr_a, last_be_a); end
    bus_cycle(1'b1, 32'h10, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (rd !== 32'hDEADABEF) begin errors++; $display("FAIL byte_readback got %h exp deadabef", rd); end
    exp_word10 = 32'hDEADABEF;
  endtask

  task automatic test_misaligned;
    int lat, kind, we0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    we0 = we_cnt_a;
    bus_cycle(1'b0, 32'h13, 2'b10, 32'h000000CD, lat, kind, rd, pds, pb, pdata);
`ifdef M68K30_SLAVE_RANGE_CHECK_EN
    checks++; if (kind !== 2 || we_cnt_a !== we0) begin errors++; $display("FAIL word13_berr got kind %0d we %0d exp 2 0", kind, we_cnt_a - we0); end
    bus_cycle(1'b0, 32'h11, 2'b00, 32'h00112233, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 2 || we_cnt_a !== we0) begin errors++; $display("FAIL long11_berr got kind %0d we %0d exp 2 0", kind, we_cnt_a - we0); end
`else
    checks++; if (kind !== 1 || {last_addr_a, last_be_a} !== {6'd4, 4'b0001}) begin errors++; $display("FAIL word13_be got kind %0d %0d/%b exp 1 4/0001", kind, last_addr_a, last_be_a); end
    bus_cycle(1'b0, 32'h11, 2'b00, 32'h00112233, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || {last_addr_a, last_be_a} !== {6'd4, 4'b0111}) begin errors++; $display("FAIL long11_be got kind %0d %0d/%b exp 1 4/0111", kind, last_addr_a, last_be_a); end
    exp_word10 = 32'hDE112233;
`endif
    bus_cycle(1'b1, 32'h10, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (rd !== exp_word10) begin errors++; $display("FAIL misaligned_readback got %h exp %h", rd, exp_word10); end
  endtask

  task automatic test_back_to_back;
    int lat1, lat2, kind1, kind2, we0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    we0 = we_cnt_a;
    bus_cycle(1'b0, 32'h20, 2'b00, 32'h11111111, lat1, kind1, rd, pds, pb, pdata);
    bus_cycle(1'b0, 32'h24, 2'b00, 32'h22222222, lat2, kind2, rd, pds, pb, pdata);
    checks++; if (lat1 !== 3 || lat2 !== 3 || kind1 !== 1 || kind2 !== 1) begin errors++; $display("FAIL b2b_latency got %0d/%0d exp 3/3", lat1, lat2); end
    checks++; if (we_cnt_a - we0 !== 2) begin errors++; $display("FAIL b2b_we_count got %0d exp 2", we_cnt_a - we0); end
    bus_cycle(1'b1, 32'h24, 2'b00, 32'h0, lat1, kind1, rd, pds, pb, pdata);
    checks++; if (rd !== 32'h22222222) begin errors++; $display("FAIL b2b_read24 got %h exp 22222222", rd); end
    bus_cycle(1'b1, 32'h20, 2'b00, 32'h0, lat1, kind1, rd, pds, pb, pdata);
    checks++; if (rd !== 32'h11111111) begin errors++; $display("FAIL b2b_read20 got %h exp 11111111", rd); end
  endtask

  task automatic test_early_abort;
    int lat, kind, we0, re0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb; bit saw;
    sel_b = 1'b1; we0 = we_cnt_b; re0 = re_cnt_b; saw = 1'b0;
    ADR_IN = 32'h30; SIZE = 2'b00; RWn = 1'b0; DATA_WR = 32'h12345678; ASn = 1'b0; DSn = 1'b0;
    @(posedge CLK); #1;
    ASn = 1'b1; DSn = 1'b1;
    repeat (8) begin @(posedge CLK); #1; if (dsack_n !== 2'b11) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL abort_dsack got asserted exp 11 throughout"); end
    checks++; if (we_cnt_b !== we0 || re_cnt_b !== re0) begin errors++; $display("FAIL abort_strobes got we %0d re %0d exp 0 0", we_cnt_b - we0, re_cnt_b - re0); end
    bus_cycle(1'b0, 32'h30, 2'b00, 32'hA5A5A5A5, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || lat !== 5 || we_cnt_b - we0 !== 1) begin errors++; $display("FAIL ws3_write got kind %0d lat %0d we %0d exp 1 5 1", kind, lat, we_cnt_b - we0); end
    bus_cycle(1'b1, 32'h30, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || lat !== 6 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL ws3_read got kind %0d lat %0d data %h exp 1 6 a5a5a5a5", kind, lat, rd); end
    sel_b = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat, kind, we0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    we0 = we_cnt_a;
    ADR_IN = 32'h10; SIZE = 2'b00; RWn = 1'b0; DATA_WR = 32'h55AA55AA; ASn = 1'b0; DSn = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #1;
    checks++; if ({a_mem_addr, a_mem_be} !== {6'd4, 4'b1111}) begin errors++; $display("FAIL mid_wait_decode got %0d/%b exp 4/1111", a_mem_addr, a_mem_be); end
    RESET_INn = 1'b0;
    #1;
    checks++; if ({a_dsack_n, a_berr_n, a_mem_we, a_mem_re} !== 5'b11100) begin errors++; $display("FAIL mid_reset_ctrl got %b exp 11100", {a_dsack_n, a_berr_n, a_mem_we, a_mem_re}); end
    checks++; if ({a_mem_addr, a_mem_be} !== 10'd0) begin errors++; $display("FAIL mid_reset_addr_be got %0d/%b exp 0/0000", a_mem_addr, a_mem_be); end
    ASn = 1'b1; DSn = 1'b1;
    @(negedge CLK) RESET_INn = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    checks++; if (we_cnt_a !== we0) begin errors++; $display("FAIL mid_reset_no_write got %0d exp 0", we_cnt_a - we0); end
    bus_cycle(1'b1, 32'h10, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 1 || rd !== exp_word10) begin errors++; $display("FAIL mid_reset_ram got %h exp %h", rd, exp_word10); end
  endtask

  task automatic test_range;
    int lat, kind, re0; logic [31:0] rd, pdata; logic [1:0] pds; logic pb;
    bus_cycle(1'b0, 32'h00, 2'b00, 32'h01234567, lat, kind, rd, pds, pb, pdata);
    re0 = re_cnt_a;
    bus_cycle(1'b1, 32'h100, 2'b00, 32'h0, lat, kind, rd, pds, pb, pdata);
`ifdef M68K30_SLAVE_RANGE_CHECK_EN
    checks++; if (kind !== 2 || re_cnt_a !== re0) begin errors++; $display("FAIL range_berr got kind %0d re %0d exp 2 0", kind, re_cnt_a - re0); end
    checks++; if (pb !== 1'b1 || pds !== 2'b11) begin errors++; $display("FAIL range_release got %b/%b exp 1/11", pb, pds); end
    bus_cycle(1'b1, 32'h13, 2'b10, 32'h0, lat, kind, rd, pds, pb, pdata);
    checks++; if (kind !== 2) begin errors++; $display("FAIL range_word13 got kind %0d exp 2", kind); end
`else
    checks++; if (kind !== 1 || rd !== 32'h01234567) begin errors++; $display("FAIL range_wrap got kind %0d data %h exp 1 01234567", kind, rd); end
    checks++; if (pb !== 1'b1 || re_cnt_a - re0 !== 1) begin errors++; $display("FAIL range_nocheck got berr %b re %0d exp 1 1", pb, re_cnt_a - re0); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_word10 = 32'h0;
    test_reset();
    test_write_read();
    test_byte_write();
    test_misaligned();
    test_back_to_back();
    test_early_abort();
    test_reset_mid();
    test_range();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
